// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into rk_0..rk_31, one per cycle, as a key-buffer write stream.
// Optional macro SM4_KEY_DEC_ORDER_EN adds dec_mode, which writes the keys at reversed addresses for decryption.

module sm4_key_expand #(
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int KEY_EXPAND_NUM = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*WORD_WIDTH-1:0] mkey,
`ifdef SM4_KEY_DEC_ORDER_EN
    input  logic                    dec_mode,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    w_en,
    output logic [ADDR_WIDTH-1:0]   w_addr,
    output logic [WORD_WIDTH-1:0]   data_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(KEY_EXPAND_NUM - 1);

    localparam logic [WORD_WIDTH-1:0] FK0 = 32'hA3B1BAC6;
    localparam logic [WORD_WIDTH-1:0] FK1 = 32'h56AA3350;
    localparam logic [WORD_WIDTH-1:0] FK2 = 32'h677D9197;
    localparam logic [WORD_WIDTH-1:0] FK3 = 32'hB27022DC;

    // S-box entry 0 sits in the most significant byte
    localparam logic [2047:0] SBOX_ROM = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sboxLookup(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_ROM[idx +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        FIN
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] k0_q, k1_q, k2_q, k3_q;
    logic [WORD_WIDTH-1:0] k0_d, k1_d, k2_d, k3_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wEn_q, wEn_d;
    logic [ADDR_WIDTH-1:0] wAddr_q, wAddr_d;
    logic [WORD_WIDTH-1:0] dataOut_q, dataOut_d;

    logic [WORD_WIDTH-1:0] ckWord;
    logic [WORD_WIDTH-1:0] tIn;
    logic [WORD_WIDTH-1:0] tauOut;
    logic [WORD_WIDTH-1:0] lOut;
    logic [WORD_WIDTH-1:0] rk;
    logic [ADDR_WIDTH-1:0] outAddr;

    logic                  lastRound;
    assign lastRound = (cnt_q == LAST_CNT);

    // CK_i is produced from the round counter: byte j = (4i+j)*7 mod 256
    always_comb begin : ckGen
        logic [7:0] ckIdx;
        ckWord = '0;
        ckIdx  = '0;
        for (int j = 0; j < 4; j++) begin
            ckIdx = 8'({cnt_q, 2'b00}) + 8'(j);
            ckWord[8*(3-j) +: 8] = ckIdx * 8'd7;
        end
    end

    always_comb begin
        tIn    = k1_q ^ k2_q ^ k3_q ^ ckWord;
        tauOut = '0;
        for (int j = 0; j < WORD_WIDTH/8; j++) begin
            tauOut[8*j +: 8] = sboxLookup(tIn[8*j +: 8]);
        end
        lOut = tauOut
             ^ ((tauOut << 13) | (tauOut >> (WORD_WIDTH - 13)))
             ^ ((tauOut << 23) | (tauOut >> (WORD_WIDTH - 23)));
        rk   = k0_q ^ lOut;
    end

`ifdef SM4_KEY_DEC_ORDER_EN
    logic decMode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decMode_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            decMode_q <= dec_mode;
        end
    end

    assign outAddr = decMode_q ? (LAST_CNT - cnt_q) : cnt_q;
`else
    assign outAddr = cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXPAND;
            EXPAND:  if (lastRound) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy stays high through the final write; done fires on the FIN cycle alone
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        wEn_d     = 1'b0;
        wAddr_d   = wAddr_q;
        dataOut_d = dataOut_q;
        case (state_q)
            IDLE: begin
                if (start) busy_d = 1'b1;
            end
            EXPAND: begin
                busy_d    = 1'b1;
                wEn_d     = 1'b1;
                wAddr_d   = outAddr;
                dataOut_d = rk;
            end
            FIN: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // The four schedule words act as a shift register with the new key entering at K3
    always_comb begin
        cnt_d = cnt_q;
        k0_d  = k0_q;
        k1_d  = k1_q;
        k2_d  = k2_q;
        k3_d  = k3_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k0_d  = mkey[4*WORD_WIDTH-1 -: WORD_WIDTH] ^ FK0;
                    k1_d  = mkey[3*WORD_WIDTH-1 -: WORD_WIDTH] ^ FK1;
                    k2_d  = mkey[2*WORD_WIDTH-1 -: WORD_WIDTH] ^ FK2;
                    k3_d  = mkey[WORD_WIDTH-1   -: WORD_WIDTH] ^ FK3;
                    cnt_d = '0;
                end
            end
            EXPAND: begin
                k0_d  = k1_q;
                k1_d  = k2_q;
                k2_d  = k3_q;
                k3_d  = rk;
                cnt_d = lastRound ? '0 : cnt_q + ADDR_WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            k0_q      <= '0;
            k1_q      <= '0;
            k2_q      <= '0;
            k3_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wEn_q     <= 1'b0;
            wAddr_q   <= '0;
            dataOut_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            k0_q      <= k0_d;
            k1_q      <= k1_d;
            k2_q      <= k2_d;
            k3_q      <= k3_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wEn_q     <= wEn_d;
            wAddr_q   <= wAddr_d;
            dataOut_q <= dataOut_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign w_en     = wEn_q;
    assign w_addr   = wAddr_q;
    assign data_out = dataOut_q;

endmodule

// File: tb/tb_sm4_key_expand.sv
// Testbench for sm4_key_expand: a textbook SM4 key-schedule model plus a per-cycle timeline compare.
// Build with SM4_KEY_DEC_ORDER_EN defined to also exercise the reversed-address mode.

module tb_sm4_key_expand;

    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start   = 1'b0;
    logic [127:0] mkey    = '0;
    logic         decMode = 1'b0;

    logic         busy;
    logic         done;
    logic         w_en;
    logic [4:0]   w_addr;
    logic [31:0]  data_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [2047:0] sboxFlat;
    logic [7:0]    sboxTab [256];

    // Model timeline: -1 idle, otherwise number of clock edges since the accepted start edge
    int            phase     = -1;
    logic [1023:0] modelKeys = '0;
    logic          modelDec  = 1'b0;

    int totalWrites = 0;
    int doneCount   = 0;
    int writeCount [32];
    int baseWrites;
    int baseDone;
    int baseCount [32];

    sm4_key_expand dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mkey     (mkey),
`ifdef SM4_KEY_DEC_ORDER_EN
        .dec_mode (decMode),
`endif
        .busy     (busy),
        .done     (done),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tPrime(input logic [31:0] x);
        logic [31:0] b;
        b = '0;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = sboxTab[x[8*j +: 8]];
        return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
    endfunction

    function automatic logic [31:0] ckConst(input int i);
        logic [31:0] c;
        c = '0;
        for (int j = 0; j < 4; j++) c = (c << 8) | 32'(((4*i + j) * 7) % 256);
        return c;
    endfunction

    // rk_i is returned at bits [32*i +: 32]
    function automatic logic [1023:0] sm4Schedule(input logic [127:0] mk);
        logic [31:0]   k [36];
        logic [31:0]   fk [4];
        logic [1023:0] r;
        fk[0] = 32'hA3B1BAC6;
        fk[1] = 32'h56AA3350;
        fk[2] = 32'h677D9197;
        fk[3] = 32'hB27022DC;
        for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ fk[j];
        r = '0;
        for (int i = 0; i < 32; i++) begin
            k[i+4] = k[i] ^ tPrime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ckConst(i));
            r[32*i +: 32] = k[i+4];
        end
        return r;
    endfunction

    function automatic logic [4:0] expAddr(input int idx, input logic dec);
        return dec ? 5'(31 - idx) : 5'(idx);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at time %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= -1;
        end else if (phase == -1 || phase == 33) begin
            if (start) begin
                modelKeys <= sm4Schedule(mkey);
                modelDec  <= decMode;
                phase     <= 0;
            end else begin
                phase <= -1;
            end
        end else begin
            phase <= phase + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_w_en", w_en, 0);
            checkOutput("rst_w_addr", w_addr, 0);
            checkOutput("rst_data_out", data_out, 0);
        end else begin
            if (w_en === 1'b1) begin
                totalWrites++;
                writeCount[w_addr]++;
            end
            if (done === 1'b1) doneCount++;
            if (phase >= 1 && phase <= 32) begin
                checkOutput("run_w_en", w_en, 1);
                checkOutput("run_busy", busy, 1);
                checkOutput("run_done", done, 0);
                checkOutput("run_w_addr", w_addr, expAddr(phase - 1, modelDec));
                checkOutput("run_data_out", data_out, modelKeys[32*(phase-1) +: 32]);
            end else if (phase == 33) begin
                checkOutput("fin_w_en", w_en, 0);
                checkOutput("fin_busy", busy, 0);
                checkOutput("fin_done", done, 1);
            end else if (phase == -1) begin
                checkOutput("idle_w_en", w_en, 0);
                checkOutput("idle_busy", busy, 0);
                checkOutput("idle_done", done, 0);
            end else begin
                checkOutput("launch_w_en", w_en, 0);
                checkOutput("launch_done", done, 0);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; start is sampled on the following rising edge
    task automatic applyStimulus(input logic [127:0] mk, input logic dec);
        start   = 1'b1;
        mkey    = mk;
        decMode = dec;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_within_budget", done, 1);
    endtask

    task automatic snapshotCounts();
        baseWrites = totalWrites;
        baseDone   = doneCount;
        for (int i = 0; i < 32; i++) baseCount[i] = writeCount[i];
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [1023:0] stdKeys;
        logic [1023:0] zeroKeys;
        int            badAddr;

        sboxFlat = {
            128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
            128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
            128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
            128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
            128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
            128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
            128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
            128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
        };
        for (int i = 0; i < 256; i++) sboxTab[i] = sboxFlat[2047-8*i -: 8];
        for (int i = 0; i < 32; i++) writeCount[i] = 0;

        stdKeys = sm4Schedule(STD_KEY);
        checkOutput("model_rk0", stdKeys[31:0], 32'hF12186F9);
        checkOutput("model_rk1", stdKeys[63:32], 32'h41662B61);
        checkOutput("model_rk31", stdKeys[1023:992], 32'h9124A012);

        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] standard vector with a stray start in cycle 10");
        snapshotCounts();
        applyStimulus(STD_KEY, 1'b0);
        waitCycles(1);
        checkOutput("std_c1_data", data_out, 32'hF12186F9);
        checkOutput("std_c1_addr", w_addr, 0);
        waitCycles(1);
        checkOutput("std_c2_data", data_out, 32'h41662B61);
        checkOutput("std_c2_addr", w_addr, 1);
        waitCycles(8);
        start = 1'b1;
        mkey  = '0;
        waitCycles(1);
        start = 1'b0;
        waitCycles(21);
        checkOutput("std_c32_data", data_out, 32'h9124A012);
        checkOutput("std_c32_addr", w_addr, 31);
        waitCycles(1);
        checkOutput("std_c33_done", done, 1);
        waitCycles(1);
        checkOutput("std_c34_done", done, 0);
        checkOutput("std_write_count", totalWrites - baseWrites, 32);
        checkOutput("std_done_count", doneCount - baseDone, 1);

`ifdef SM4_KEY_DEC_ORDER_EN
        $display("[TB] decryption address order");
        applyStimulus(STD_KEY, 1'b1);
        waitCycles(1);
        checkOutput("dec_c1_addr", w_addr, 31);
        checkOutput("dec_c1_data", data_out, 32'hF12186F9);
        waitCycles(31);
        checkOutput("dec_c32_addr", w_addr, 0);
        checkOutput("dec_c32_data", data_out, 32'h9124A012);
        waitDone();
        waitCycles(1);
`endif

        $display("[TB] reset in the middle of an expansion");
        applyStimulus(STD_KEY, 1'b0);
        waitCycles(15);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_w_en", w_en, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_w_addr", w_addr, 0);
        checkOutput("midrst_data_out", data_out, 0);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
        applyStimulus(STD_KEY, 1'b0);
        waitCycles(1);
        checkOutput("restart_c1_data", data_out, 32'hF12186F9);
        waitDone();
        waitCycles(1);

        $display("[TB] back-to-back expansions");
        zeroKeys = sm4Schedule('0);
        snapshotCounts();
        applyStimulus(STD_KEY, 1'b0);
        waitCycles(33);
        checkOutput("b2b_first_done", done, 1);
        applyStimulus('0, 1'b0);
        waitCycles(1);
        checkOutput("b2b_c1_addr", w_addr, 0);
        checkOutput("b2b_c1_data", data_out, zeroKeys[31:0]);
        waitDone();
        waitCycles(1);
        checkOutput("b2b_write_count", totalWrites - baseWrites, 64);
        checkOutput("b2b_done_count", doneCount - baseDone, 2);
        badAddr = 0;
        for (int i = 0; i < 32; i++) if (writeCount[i] - baseCount[i] != 2) badAddr++;
        checkOutput("b2b_each_addr_twice", badAddr, 0);

        $display("[TB] random master keys");
        repeat (100) begin
            logic dec;
`ifdef SM4_KEY_DEC_ORDER_EN
            dec = 1'($urandom_range(0, 1));
`else
            dec = 1'b0;
`endif
            snapshotCounts();
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, dec);
            waitDone();
            waitCycles(1);
            checkOutput("rand_write_count", totalWrites - baseWrites, 32);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sm4_key_expand.md
Name: sm4_key_expand

Overview:
- Upstream producer for the round-key buffer.
- Accepts a 128-bit SM4 master key (MK) and runs the SM4 key schedule, one round key per cycle.
- Emits rk_0..rk_31 as a word-wide write stream (w_en / w_addr / data_out) that connects directly to the buffer's write port.
- Handshake: start/busy/done, driven by the top-level controller.

Parameters:
- WORD_WIDTH, 32, width of one round key / schedule word.
- ADDR_WIDTH, 5, width of the buffer write address.
- KEY_EXPAND_NUM, 32, number of round keys generated per expansion.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an expansion; sampled only in IDLE.
- mkey  input  4*WORD_WIDTH  master key; MK0 = mkey[127:96], MK3 = mkey[31:0]; sampled with start.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse after the last key is written.
- w_en  output  1  write strobe to the key buffer.
- w_addr  output  ADDR_WIDTH  write address (round index).
- data_out  output  WORD_WIDTH  round key rk_i.

Behaviour:
- Reset: one clock; rst_n is asynchronous, active-low. While rst_n=0:
  - state=IDLE, round counter=0, K0..K3=0.
  - busy=0, done=0, w_en=0, w_addr=0, data_out=0.
- All outputs are registered.
- FSM states: IDLE, EXPAND, FIN.
- IDLE:
  - On start=1, load K_j = MK_j ^ FK_j with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Same edge: cnt<=0, busy<=1, go to EXPAND.
  - start=0: remain in IDLE.
- EXPAND, each cycle:
  - rk = K0 ^ T'(K1^K2^K3^CK_cnt).
  - Register w_en<=1, w_addr<=cnt, data_out<=rk.
  - Shift K0<=K1, K1<=K2, K2<=K3, K3<=rk; cnt<=cnt+1.
  - When cnt=KEY_EXPAND_NUM-1, go to FIN.
- FIN:
  - w_en<=0, busy<=0, done<=1 for exactly one cycle, then IDLE.
- T' = L'(tau(x)):
  - tau applies the SM4 S-box bytewise, four combinational copies from an internal 256-entry ROM function.
  - L'(B) = B ^ (B<<<13) ^ (B<<<23).
- CK_i is generated on the fly, with no table:
  - byte j (j=0 is the MSB) = ((4i+j)*7) mod 256, truncated to 8 bits.
- Latency:
  - rk_i appears on the write port in cycle i+1 after the start edge.
  - w_en is high for exactly cycles 1..32.
  - done is high in cycle 33.
  - busy is high in cycles 1..32.
  - start may be reasserted in cycle 34.
- start while busy or in FIN: ignored; mkey is not resampled.
- Counter wrap: cnt never exceeds KEY_EXPAND_NUM-1; exactly 32 writes per start.
- Reset mid-expansion:
  - Immediate return to IDLE and all outputs 0.
  - The buffer holds a partial key set; the controller must restart.
- The block has no backpressure; the downstream buffer accepts every write.

Optional Feature:
- Macro: SM4_KEY_DEC_ORDER_EN.
- Defined:
  - Adds input dec_mode (1 bit), sampled with start.
  - When dec_mode=1, w_addr = KEY_EXPAND_NUM-1-cnt, so rk_31 lands at address 0 and the buffer is read in decryption order without address remapping.
  - data_out ordering in time is unchanged.
- Undefined:
  - No dec_mode port; w_addr = cnt always.

Test Plan:
- Standard vector: mkey=0123456789ABCDEFFEDCBA9876543210, start for 1 cycle -> cycle 1: w_addr=0, data_out=F12186F9; cycle 2: w_addr=1, data_out=41662B61; cycle 32: w_addr=31, data_out=9124A012; done=1 in cycle 33 only; exactly 32 w_en cycles.
- Ignored start: pulse start=1 with mkey=0 in cycle 10 of the run above -> stream identical to the standard vector; no second expansion.
- Reset mid-run: drop rst_n in cycle 15 -> busy, w_en, done, w_addr and data_out all 0 immediately. After release, restart with the standard vector -> cycle 1 data_out=F12186F9.
- Back-to-back: start again in cycle 34 with mkey=0 -> cycle 1 of the new run has w_addr=0 and data_out equal to the golden-model rk_0 for MK=0; total 64 writes over the two runs, each address written twice.
- With SM4_KEY_DEC_ORDER_EN, dec_mode=1, standard vector -> cycle 1: w_addr=31, data_out=F12186F9; cycle 32: w_addr=0, data_out=9124A012.
- Random MKs (100 runs) vs. a software SM4 key-schedule model -> all 32 keys and addresses match; busy/done timing as specified.
